toggle_event_decoder: RTL and testbench
=======================================

// Module: toggle_event_decoder
// PURPOSE
//   Receive-side decoder for the 2-phase toggle line driven by the team's toggle flip-flop.
//   On the sender side, each t=1 clock makes q invert, so every transition of q is one event.
//   This block synchronises that line and rejects glitches.
//   Each accepted transition becomes one queued event, and queued events are handed to the
//   consumer over a valid/ready handshake.
//   It also keeps a local mirror of the sender's q and a running event total.
// PARAMETERS
//   FILT   default 2   input must differ from q_mirror for FILT consecutive cycles to be accepted (>=1)
//   CNT_W  default 4   width of the pending-event counter; max pending = 2**CNT_W-1
//   TOT_W  default 16  width of the total accepted-event counter (wraps)
// PORTS
//   clk        input   1      system clock, rising edge
//   rst_n      input   1      asynchronous active-low reset
//   tog_in     input   1      toggle line from the remote toggle flip-flop (asynchronous to clk)
//   ev_valid   output  1      at least one event is pending
//   ev_ready   input   1      consumer accepts one event when ev_valid&ev_ready at a rising edge
//   pending    output  CNT_W  number of queued, unconsumed events
//   overflow   output  1      sticky: an event was accepted while pending was full
//   q_mirror   output  1      filtered reconstruction of the sender's q
//   ev_total   output  TOT_W  count of all accepted transitions, modulo 2**TOT_W
// BEHAVIOUR
//   Reset (rst_n=0, async):
//     - sync regs s1,s2=0, q_mirror=0, flt_cnt=0, state=IDLE.
//     - pending=0, ev_valid=0, overflow=0, ev_total=0.
//     - A reset mid-filter or with events pending discards everything.
//     - On release, the first accepted transition is tog_in going 0->1.
//   Synchroniser: s1<=tog_in, s2<=s1 on every edge. Logic uses only s2.
//   FSM, 2 states:
//     IDLE:   s2==q_mirror -> stay, flt_cnt=0.
//             s2!=q_mirror -> if FILT==1 accept now, else go to FILTER with flt_cnt=1.
//     FILTER: s2==q_mirror -> back to IDLE, flt_cnt=0 (glitch rejected, no event).
//             s2!=q_mirror and flt_cnt==FILT-1 -> accept, go to IDLE, flt_cnt=0.
//             otherwise flt_cnt+1.
//     Accept: q_mirror<=~q_mirror, ev_total<=ev_total+1 (wraps), acc=1 for that edge.
//   Latency:
//     - tog_in changes before edge k: s2 updates at k+1.
//     - Accept at edge k+1+FILT, so pending/ev_valid update after that edge (FILT=2 -> edge k+3).
//   Pending counter, per edge (pop = ev_valid & ev_ready):
//     - acc & ~pop: pending+1; if pending==max, pending holds and overflow<=1.
//     - ~acc & pop: pending-1.
//     - acc & pop: pending unchanged (also when full; no overflow).
//     - ev_ready while pending==0: ignored, pending stays 0 (no underflow).
//   Output decode:
//     - ev_valid = (pending!=0), a registered decode, never combinational from ev_ready.
//     - overflow clears only on reset.
//   Input rate: transitions spaced closer than FILT+1 cycles can be merged or rejected;
//     the sender must hold each level >= FILT+2 clk cycles.
// TESTING
//   1. Reset then release, tog_in=0 held 10 cycles -> pending=0, ev_valid=0, q_mirror=0, ev_total=0.
//   2. FILT=2, tog_in 0->1, ev_ready=0 -> ev_valid=1 and pending=1 three edges later, q_mirror=1.
//   3. tog_in 1-cycle glitch high then low -> no accept: pending, ev_total, q_mirror unchanged.
//   4. 16 transitions spaced 6 cycles, ev_ready=0, CNT_W=4 -> pending=15, overflow=1, ev_total=16.
//   5. pending=15, accept coinciding with ev_ready=1 -> pending stays 15, overflow stays 0.
//      Then ev_ready=1 for 20 cycles -> pending 0, no underflow.
//   6. pending=3 and FSM in FILTER, assert rst_n=0 mid-cycle -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/toggle_event_decoder.sv
// Receive-side decoder for a 2-phase toggle line: synchronises the line, rejects
// short glitches, mirrors the sender's q and queues one event per accepted transition.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | synchronised line matches q_mirror, nothing being qualified
// FILTER | line differs from q_mirror, counting cycles until acceptance
module toggle_event_decoder #(
   parameter int FILT  = 2,
   parameter int CNT_W = 4,
   parameter int TOT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tog_in,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [CNT_W-1:0] pending,
   output logic             overflow,
   output logic             q_mirror,
   output logic [TOT_W-1:0] ev_total
);

   localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;
   localparam logic [FW-1:0]    FLT_LAST = FW'(FILT - 1);
   localparam logic [CNT_W-1:0] PEND_MAX = '1;

   typedef enum logic {
      IDLE   = 1'b0,
      FILTER = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [FW-1:0]     flt_cnt, flt_cnt_nxt;
   logic              s1, s2;
   logic              acc;
   logic              pop;
   logic [CNT_W-1:0]  pending_nxt;
   logic              ovf_set;

   // Two-flop synchroniser for the asynchronous toggle line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= tog_in;
         s2 <= s1;
      end
   end

   // FSM state, filter counter, mirrored q and running total.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         flt_cnt  <= '0;
         q_mirror <= 1'b0;
         ev_total <= '0;
      end else begin
         state   <= state_nxt;
         flt_cnt <= flt_cnt_nxt;
         if (acc) begin
            q_mirror <= ~q_mirror;
            ev_total <= ev_total + 1'b1;
         end
      end
   end

   // Glitch filter: a difference must persist FILT cycles before it is accepted.
   always_comb begin
      state_nxt   = state;
      flt_cnt_nxt = flt_cnt;
      acc         = 1'b0;
      case (state)
         IDLE: begin
            flt_cnt_nxt = '0;
            if (s2 != q_mirror) begin
               if (FILT == 1) begin
                  acc = 1'b1;
               end else begin
                  state_nxt   = FILTER;
                  flt_cnt_nxt = FW'(1);
               end
            end
         end
         FILTER: begin
            if (s2 == q_mirror) begin
               state_nxt   = IDLE;
               flt_cnt_nxt = '0;
            end else if (flt_cnt == FLT_LAST) begin
               acc         = 1'b1;
               state_nxt   = IDLE;
               flt_cnt_nxt = '0;
            end else begin
               flt_cnt_nxt = flt_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt   = IDLE;
            flt_cnt_nxt = '0;
         end
      endcase
   end

   // Pending-count arithmetic; a simultaneous accept and pop cancel, even when full.
   always_comb begin
      pop         = ev_valid & ev_ready;
      pending_nxt = pending;
      ovf_set     = 1'b0;
      if (acc && !pop) begin
         if (pending == PEND_MAX) begin
            ovf_set = 1'b1;
         end else begin
            pending_nxt = pending + 1'b1;
         end
      end else if (!acc && pop) begin
         pending_nxt = pending - 1'b1;
      end
   end

   // Event queue registers; ev_valid is a registered decode of the next pending count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= '0;
         ev_valid <= 1'b0;
         overflow <= 1'b0;
      end else begin
         pending  <= pending_nxt;
         ev_valid <= (pending_nxt != '0);
         if (ovf_set) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Bench for toggle_event_decoder: stimulus pushes the edge at which each
// transition should be accepted; a monitor pops those on accept and tracks
// the expected queue state with a behavioural model.
module tb_toggle_event_decoder;

   localparam int FILT  = 2;
   localparam int CNT_W = 4;
   localparam int TOT_W = 16;
   localparam int PMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             tog_in = 1'b0;
   logic             ev_ready = 1'b0;
   logic             ev_valid;
   logic [CNT_W-1:0] pending;
   logic             overflow;
   logic             q_mirror;
   logic [TOT_W-1:0] ev_total;

   toggle_event_decoder #(.FILT(FILT), .CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tog_in   (tog_in),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .pending  (pending),
      .overflow (overflow),
      .q_mirror (q_mirror),
      .ev_total (ev_total)
   );

   always #5 clk = ~clk;

   int  errors = 0;
   int  checks = 0;
   int  cyc = 0;
   int  acc_q[$];
   bit  mon_en = 1'b0;
   bit  async_chk = 1'b0;
   bit  done = 1'b0;
   bit  rand_rdy = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: behavioural model of the event queue, compared after every edge.
   initial begin : monitor
      bit              rdy;
      bit              acc;
      bit              pop;
      bit              seen;
      int              mp;
      bit              mov;
      bit              mq;
      int unsigned     mtot;
      logic [TOT_W-1:0] prev_tot;
      mp = 0; mov = 0; mq = 0; mtot = 0; prev_tot = '0;
      forever begin
         @(posedge clk);
         cyc++;
         rdy = ev_ready;
         @(negedge clk);
         if (done) begin
            chk("leftover_events", acc_q.size(), 0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
         end
         if (async_chk) begin
            chk("async_pending", pending, 0);
            chk("async_ev_valid", ev_valid, 0);
            chk("async_overflow", overflow, 0);
            chk("async_q_mirror", q_mirror, 0);
            chk("async_ev_total", ev_total, 0);
         end
         if (!mon_en) begin
            mp = 0; mov = 0; mq = 0; mtot = 0; prev_tot = '0;
            acc_q.delete();
         end else begin
            acc  = (acc_q.size() > 0) && (acc_q[0] == cyc);
            seen = (ev_total != prev_tot);
            if (seen || acc) begin
               chk("accept_timing", seen, acc);
            end
            if (acc) begin
               void'(acc_q.pop_front());
               mtot++;
               mq = ~mq;
            end
            prev_tot = ev_total;
            pop = (mp != 0) && rdy;
            if (acc && !pop) begin
               if (mp == PMAX) mov = 1'b1;
               else mp++;
            end else if (!acc && pop) begin
               mp--;
            end
            chk("pending", pending, mp);
            chk("ev_valid", ev_valid, (mp != 0));
            chk("overflow", overflow, mov);
            chk("q_mirror", q_mirror, mq);
            chk("ev_total", ev_total, mtot % (1 << TOT_W));
         end
      end
   end

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (rand_rdy) ev_ready = 1'($urandom_range(0, 1));
      end
   endtask

   // Flip the line and record when the decoder should accept it.
   task automatic do_tog(input int hold);
      tog_in = ~tog_in;
      if (mon_en) acc_q.push_back(cyc + 2 + FILT);
      wait_cycles(hold);
   endtask

   task automatic do_glitch();
      tog_in = ~tog_in;
      wait_cycles(1);
      tog_in = ~tog_in;
      wait_cycles(3);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #2;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      tog_in = 1'b0;
      ev_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
   endtask

   initial begin : stimulus
      // reset, line idle
      apply_reset();
      wait_cycles(10);
      // single transition, no consumer
      do_tog(8);
      // one-cycle glitch is rejected
      do_glitch();
      wait_cycles(4);
      // 16 transitions saturate the queue and set overflow
      apply_reset();
      for (int i = 0; i < 16; i++) do_tog(6);
      wait_cycles(4);
      // fill to 15, then accept coinciding with a pop keeps 15 with no overflow
      apply_reset();
      for (int i = 0; i < 15; i++) do_tog(6);
      tog_in = ~tog_in;
      acc_q.push_back(cyc + 2 + FILT);
      wait_cycles(3);
      ev_ready = 1'b1;
      wait_cycles(1);
      ev_ready = 1'b0;
      wait_cycles(3);
      ev_ready = 1'b1;
      wait_cycles(20);
      ev_ready = 1'b0;
      wait_cycles(3);
      // async reset with events pending and FSM qualifying a transition
      apply_reset();
      for (int i = 0; i < 3; i++) do_tog(6);
      tog_in = ~tog_in;
      repeat (3) @(posedge clk);
      #2;
      mon_en    = 1'b0;
      async_chk = 1'b1;
      rst_n     = 1'b0;
      @(negedge clk);
      #1;
      async_chk = 1'b0;
      tog_in    = 1'b0;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      wait_cycles(6);
      // randomized transitions, glitches and consumer backpressure
      apply_reset();
      rand_rdy = 1'b1;
      for (int i = 0; i < 200; i++) begin
         do_tog($urandom_range(FILT + 2, 10));
         if ($urandom_range(0, 3) == 0) do_glitch();
      end
      ev_ready = 1'b1;
      rand_rdy = 1'b0;
      wait_cycles(20);
      done = 1'b1;
      forever @(negedge clk);
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
